// File: rtl/cla_pipe_adder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder_if
// Purpose  : Operand/result handshake bundle for cla_pipe_adder.
//            The sub select exists only when CLA_PIPE_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

`ifdef CLA_PIPE_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined two-level carry-lookahead adder with valid/ready flow.
//            Optional subtract mode enabled by defining CLA_PIPE_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    cla_pipe_adder_if.slave  bus
);
    localparam int SEG_W = WIDTH / STAGES;
    localparam int GPS   = SEG_W / 4;

    // Returns {carry_out, sum} of one segment; group carries are sum-of-products
    // of group G/P terms, so no carry ripples between groups.
    function automatic logic [SEG_W:0] seg_add(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             c0
    );
        logic [SEG_W-1:0] p;
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] bc;
        logic [GPS-1:0]   gp;
        logic [GPS-1:0]   gg;
        logic [GPS:0]     gc;
        logic             term;
        logic             ci;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < GPS; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = c0;
        for (int j = 1; j <= GPS; j++) begin
            gc[j] = 1'b0;
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) term = term & gp[m];
                gc[j] = gc[j] | term;
            end
            term = c0;
            for (int m = 0; m < j; m++) term = term & gp[m];
            gc[j] = gc[j] | term;
        end
        for (int j = 0; j < GPS; j++) begin
            ci          = gc[j];
            bc[4*j]     = ci;
            bc[4*j+1]   = g[4*j] | (p[4*j] & ci);
            bc[4*j+2]   = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & ci);
            bc[4*j+3]   = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                        | (p[4*j+2] & p[4*j+1] & g[4*j])
                        | (p[4*j+2] & p[4*j+1] & p[4*j] & ci);
        end
        return {gc[GPS], p ^ bc};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    assign adv          = bus.out_ready | ~g_stage[STAGES-1].valid_q;
    assign bus.in_ready = adv;

    always_comb begin
`ifdef CLA_PIPE_SUB_EN
        b_in = bus.sub ? ~bus.b : bus.b;
        c_in = bus.sub ? 1'b1 : bus.cin;
`else
        b_in = bus.b;
        c_in = bus.cin;
`endif
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int REM_IN  = WIDTH - SEG_W * s;
        localparam int REM_OUT = REM_IN - SEG_W;
        localparam int DONE_W  = SEG_W * (s + 1);

        logic              src_valid;
        logic [REM_IN-1:0] src_a;
        logic [REM_IN-1:0] src_b;
        logic              src_c;
        logic [SEG_W:0]    seg;
        logic [DONE_W-1:0] sum_cat;
        logic              valid_q, valid_d;
        logic              carry_q, carry_d;
        logic [DONE_W-1:0] sum_q, sum_d;

        assign seg = seg_add(src_a[SEG_W-1:0], src_b[SEG_W-1:0], src_c);

        if (s == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_a     = bus.a;
            assign src_b     = b_in;
            assign src_c     = c_in;
            assign sum_cat   = seg[SEG_W-1:0];
        end else begin : g_body
            assign src_valid = g_stage[s-1].valid_q;
            assign src_a     = g_stage[s-1].g_fwd.a_q;
            assign src_b     = g_stage[s-1].g_fwd.b_q;
            assign src_c     = g_stage[s-1].carry_q;
            assign sum_cat   = {seg[SEG_W-1:0], g_stage[s-1].sum_q};
        end

        always_comb begin
            valid_d = adv ? src_valid : valid_q;
            carry_d = adv ? seg[SEG_W] : carry_q;
            sum_d   = adv ? sum_cat    : sum_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // Operand bits not yet consumed travel with the partial sum.
        if (REM_OUT > 0) begin : g_fwd
            logic [REM_OUT-1:0] a_q, a_d, b_q, b_d;

            always_comb begin
                a_d = adv ? src_a[REM_IN-1:SEG_W] : a_q;
                b_d = adv ? src_b[REM_IN-1:SEG_W] : b_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (s == STAGES - 1) begin : g_tail
            logic ovf_q, ovf_d, zero_q, zero_d;
            logic cmsb;

            // Sum bit = p ^ carry-in, so the carry into the MSB is recovered from it.
            assign cmsb = seg[SEG_W-1] ^ src_a[SEG_W-1] ^ src_b[SEG_W-1];

            always_comb begin
                ovf_d  = adv ? (cmsb ^ seg[SEG_W]) : ovf_q;
                zero_d = adv ? ~|sum_cat : zero_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].carry_q;
    assign bus.ovf       = g_stage[STAGES-1].g_tail.ovf_q;
    assign bus.zero      = g_stage[STAGES-1].g_tail.zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder
// Purpose  : Scoreboard bench for cla_pipe_adder (WIDTH=16, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;
    localparam int W  = 16;
    localparam int ST = 2;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tb_sub = 1'b0;
    res_t exp_q[$];
    int   acc_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    cla_pipe_adder_if #(.WIDTH(W)) bus();

    cla_pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        res_t         r;
        bb     = s ? ~b : b;
        cc     = s ? 1'b1 : c;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        tb_sub       = s;
`ifdef CLA_PIPE_SUB_EN
        bus.sub      = s;
`endif
    endtask

    // One clock: records acceptance into the scoreboard, pops on completion.
    task automatic step(output logic acc, output logic done, output res_t e,
                        output res_t got, output int lat);
        #1;
        acc  = bus.in_valid && bus.in_ready;
        done = bus.out_valid && bus.out_ready;
        got  = {bus.sum, bus.cout, bus.ovf, bus.zero};
        e    = 'x;
        lat  = -1;
        if (done && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            lat = cyc - acc_q.pop_front();
        end
        if (acc) begin
            exp_q.push_back(model(bus.a, bus.b, bus.cin, tb_sub));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        #3;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset out_valid: got %b required 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset in_ready: got %b required 1", bus.in_ready);
        end
        n_cmp++;
        if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== '0) begin
            n_bad++; $display("FAIL reset outputs: got %h/%b/%b/%b required 0/0/0/0",
                              bus.sum, bus.cout, bus.ovf, bus.zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_corners();
        logic [W-1:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        logic [W-1:0] tb [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h0000, 16'hFFFF};
        logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic acc, done; res_t e, got; int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && (i < 5 || exp_q.size() > 0); i++) begin
            if (i < 5) drive(1'b1, ta[i], tb[i], tc[i], 1'b0);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0);
            step(acc, done, e, got, lat);
            if (done) begin
                n_cmp++;
                if (got !== e) begin
                    n_bad++; $display("FAIL corner result: got %h required %h (sum,cout,ovf,zero)", got, e);
                end
                n_cmp++;
                if (lat !== ST) begin
                    n_bad++; $display("FAIL corner latency: got %0d required %0d", lat, ST);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL corner drain: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic acc, done; res_t e, got; int lat;
        int n_done = 0;
        int last   = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && (i < 8 || exp_q.size() > 0); i++) begin
            if (i < 8) drive(1'b1, W'(i), W'(32'h1000 * i), 1'b0, 1'b0);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0);
            step(acc, done, e, got, lat);
            if (done) begin
                n_cmp++;
                if (got !== e) begin
                    n_bad++; $display("FAIL b2b result %0d: got %h required %h", n_done, got, e);
                end
                n_cmp++;
                if (lat !== ST || (last >= 0 && cyc != last + 1)) begin
                    n_bad++; $display("FAIL b2b timing %0d: latency %0d required %0d", n_done, lat, ST);
                end
                last = cyc;
                n_done++;
            end
        end
        n_cmp++;
        if (n_done != 8) begin
            n_bad++; $display("FAIL b2b count: got %0d required 8", n_done);
        end
    endtask

    task automatic test_backpressure();
        logic acc, done; res_t e, got; int lat;
        int n_acc  = 0;
        int n_done = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, W'(16'h1111 * (i + 3)), W'(16'h0F0F * (i + 1)), 1'b1, 1'b0);
            step(acc, done, e, got, lat);
            n_acc += int'(acc);
        end
        drive(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall in_ready: got %b required 0", bus.in_ready);
            end
            n_cmp++;
            if (exp_q.size() == 0 || bus.out_valid !== 1'b1 ||
                {bus.sum, bus.cout, bus.ovf, bus.zero} !== exp_q[0]) begin
                n_bad++; $display("FAIL stall hold: got valid %b data %h required valid 1 data %h",
                                  bus.out_valid, {bus.sum, bus.cout, bus.ovf, bus.zero},
                                  (exp_q.size() > 0) ? exp_q[0] : res_t'('x));
            end
            step(acc, done, e, got, lat);
            n_acc += int'(acc);
        end
        n_cmp++;
        if (n_acc != 2) begin
            n_bad++; $display("FAIL stall accepts: got %0d required 2", n_acc);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (n_acc < 3 || exp_q.size() > 0); i++) begin
            if (n_acc >= 3) drive(1'b0, '0, '0, 1'b0, 1'b0);
            step(acc, done, e, got, lat);
            n_acc += int'(acc);
            if (done) begin
                n_cmp++;
                if (got !== e) begin
                    n_bad++; $display("FAIL release result %0d: got %h required %h", n_done, got, e);
                end
                n_done++;
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (n_done != 3) begin
            n_bad++; $display("FAIL release count: got %0d required 3", n_done);
        end
    endtask

    task automatic test_async_reset();
        logic acc, done; res_t e, got; int lat;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        step(acc, done, e, got, lat);
        drive(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
        step(acc, done, e, got, lat);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #0.5;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.sum !== '0) begin
            n_bad++; $display("FAIL async reset: got valid %b sum %h required valid 0 sum 0000",
                              bus.out_valid, bus.sum);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL async reset in_ready: got %b required 1", bus.in_ready);
        end
        #0.5 rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        for (int i = 0; i < 5; i++) begin
            step(acc, done, e, got, lat);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++; $display("FAIL stale after reset: got done %b sum %h required done 0", done, got.sum);
            end
        end
    endtask

    task automatic test_random();
        logic acc, done; res_t e, got; int lat;
        int n_acc  = 0;
        int n_done = 0;
        for (int i = 0; i < 200 && (i < 80 || exp_q.size() > 0); i++) begin
            if (i < 80) begin
`ifdef CLA_PIPE_SUB_EN
                drive(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
                drive(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
                bus.out_ready = ($urandom % 3) != 0;
            end else begin
                drive(1'b0, '0, '0, 1'b0, 1'b0);
                bus.out_ready = 1'b1;
            end
            step(acc, done, e, got, lat);
            n_acc += int'(acc);
            if (done) begin
                n_cmp++;
                if (got !== e) begin
                    n_bad++; $display("FAIL random result %0d: got %h required %h", n_done, got, e);
                end
                n_done++;
            end
        end
        n_cmp++;
        if (n_done != n_acc) begin
            n_bad++; $display("FAIL random count: got %0d results required %0d", n_done, n_acc);
        end
    endtask

`ifdef CLA_PIPE_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta [2] = '{16'h0005, 16'h8000};
        logic [W-1:0] tb [2] = '{16'h0007, 16'h0001};
        res_t         fixed [2] = '{{16'hFFFE, 1'b0, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1, 1'b0}};
        logic acc, done; res_t e, got; int lat;
        int n_done = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (i < 2 || exp_q.size() > 0); i++) begin
            if (i < 2) drive(1'b1, ta[i], tb[i], 1'b0, 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0);
            step(acc, done, e, got, lat);
            if (done && n_done < 2) begin
                n_cmp++;
                if (got !== e || got !== fixed[n_done]) begin
                    n_bad++; $display("FAIL sub result %0d: got %h required %h", n_done, got, fixed[n_done]);
                end
                n_done++;
            end
        end
        n_cmp++;
        if (n_done != 2) begin
            n_bad++; $display("FAIL sub count: got %0d required 2", n_done);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef CLA_PIPE_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder; successor to the fixed 4-bit CLA slice. Splits a WIDTH-bit add into STAGES register-separated segments of 4-bit lookahead groups with a second-level group lookahead inside each segment. Sits between the decode/operand-latch stage and the ALU result mux, behind a valid/ready handshake, so long adds close timing without stalling the rest of the datapath.

## Interface
- WIDTH, 16, operand/result width; multiple of 4.
- STAGES, 2, pipeline depth; WIDTH/4 divisible by STAGES; 1 ≤ STAGES ≤ WIDTH/4.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- sub  in  1  subtract select; present only with CLA_PIPE_SUB_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- GPS = WIDTH/(4*STAGES) groups per stage. Stage s (0-based) computes bits [4*GPS*s +: 4*GPS].
- Per group: bit p = a^b, g = a&b; group P/G and carries by 4-bit lookahead. Across the stage's groups: second-level lookahead on group P/G from the stage's incoming carry. No ripple between groups inside a stage.
- Stage register s holds: valid bit, completed low sum bits, carry out of the segment, unconsumed upper a/b bits, carry into the MSB (for ovf).
- Final stage register drives sum, cout, ovf = carry_into_msb ^ cout, zero = ~|sum.
- Single global advance: adv = out_ready | ~out_valid. in_ready = adv. All stage registers load when adv; hold otherwise. Bubbles (valid=0) propagate; they are not collapsed.
- Accept when in_valid & in_ready; completion when out_valid & out_ready. Results leave in acceptance order; none dropped or duplicated.
- sum/cout/ovf/zero stable while out_valid & ~out_ready.

## Timing
- Latency: result valid exactly STAGES cycles after acceptance with out_ready held high.
- Throughput: one op per cycle with out_ready high.
- in_ready combinational from out_ready and final valid; no combinational path a/b → sum.
- Reset (rst_n low, asynchronous): all valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, zero 0; data in flight discarded. in_ready = 1 while out_valid = 0.
- Reset release: first acceptance on the first rising edge with rst_n high and in_valid high.
- Simultaneous accept and complete with full pipeline: legal, both occur same edge.
- cin and operand bits enter stage 0 together; later stages use only their registered copies (input changes after acceptance have no effect).
- WIDTH wrap: sum is mod 2^WIDTH; carry lost from sum appears only on cout.

## Configuration
- CLA_PIPE_SUB_EN defined: sub port present; when sub=1 at acceptance, b is bitwise inverted and carry-in forced to 1 (cin ignored); cout = NOT borrow; ovf computed on the inverted operand. sub captured with the operands.
- Not defined: no sub port; block always computes a + b + cin.

## Test plan
- WIDTH=16, STAGES=2: a=0xFFFF, b=0x0001, cin=0 → 2 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1, zero=0; a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- 8 back-to-back ops (a=i, b=0x1000*i, i=0..7), out_ready=1 → 8 results on consecutive cycles starting cycle 2, in order.
- Issue 3 ops, hold out_ready=0 for 4 cycles → in_ready drops once pipeline full, outputs hold; release → all 3 results delivered in order, none lost.
- rst_n low for 1 ns mid-cycle with 2 ops in flight → out_valid=0 immediately, sum=0; no stale result after release.
- CLA_PIPE_SUB_EN, sub=1: a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
